prog_boot_loader: RTL and testbench

Boot/program loader that sits directly upstream of the RV32I core top. It accepts a stream of 32-bit instruction words over a valid/ready handshake and writes them sequentially into program memory. It holds the core in reset during loading, then releases it after a programmable settle delay. It supports reloading between test programs, which replaces direct memory preload and manual rst_n sequencing by the bench.

---
 rtl/prog_boot_loader.sv | 115 +++++++++++
 tb/tb_prog_boot_loader.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/prog_boot_loader.sv
// prog_boot_loader: streams 32-bit instruction words from a valid/ready
// source into program memory. The core is held in reset while the program
// loads and is released after a settle delay. A new start request reloads
// the memory from word 0.
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   start           single-cycle request to begin a (re)load
//   in_valid/ready  upstream handshake; in_data word, in_last marks the final word
//   mem_we/addr/wdata  program memory write port (one cycle after accept)
//   core_rst_n      active-low reset to the core (0 = held)
//   done            program loaded, core running
//   error           memory filled without in_last
//   word_count      words written in the current load
module prog_boot_loader #(
    parameter int unsigned ADDR_WIDTH    = 10,
    parameter int unsigned RELEASE_DELAY = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_data,
    input  logic                  in_last,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  core_rst_n,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   word_count
);

    localparam int unsigned DW = (RELEASE_DELAY == 0) ? 1 : $clog2(RELEASE_DELAY + 1);
    localparam logic [DW-1:0] DLY_INIT = DW'(RELEASE_DELAY);

    typedef enum logic [2:0] {IDLE, LOAD, DELAY, RUN, ERR} state_t;

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [DW-1:0]         dly_cnt;
    logic                  accept;
    logic                  at_top;
    logic                  load_begin;

    assign in_ready   = (state == LOAD);
    assign accept     = in_valid && in_ready;
    assign at_top     = (ptr == '1);
    // Entering LOAD from IDLE/RUN/ERR restarts the pointer and count.
    assign load_begin = (state != LOAD) && (state_next == LOAD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = LOAD;
            LOAD: begin
                if (accept) begin
                    if (in_last)     state_next = DELAY;
                    else if (at_top) state_next = ERR;
                end
            end
            DELAY:   if (dly_cnt == '0) state_next = RUN;
            RUN:     if (start) state_next = LOAD;
            ERR:     if (start) state_next = LOAD;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr        <= '0;
            dly_cnt    <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            word_count <= '0;
            core_rst_n <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            mem_we <= accept;
            if (accept) begin
                mem_addr   <= ptr;
                mem_wdata  <= in_data;
                ptr        <= ptr + 1'b1;
                word_count <= word_count + 1'b1;
            end
            if (load_begin) begin
                ptr        <= '0;
                word_count <= '0;
            end
            if (accept && in_last) begin
                dly_cnt <= DLY_INIT;
            end else if (state == DELAY && dly_cnt != '0) begin
                dly_cnt <= dly_cnt - 1'b1;
            end
            // Status outputs track the state being entered so they change on
            // the same edge as the transition.
            core_rst_n <= (state_next == RUN);
            done       <= (state_next == RUN);
            error      <= (state_next == ERR);
        end
    end

endmodule

// File: tb/tb_prog_boot_loader.sv
module tb_prog_boot_loader;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Instance A: ADDR_WIDTH=10, RELEASE_DELAY=4
    logic        start_a = 0, valid_a = 0, last_a = 0;
    logic [31:0] data_a = '0;
    logic        ready_a, we_a, crst_a, done_a, err_a;
    logic [9:0]  addr_a;
    logic [31:0] wdata_a;
    logic [10:0] wc_a;

    // Instance B: ADDR_WIDTH=2, RELEASE_DELAY=0
    logic        start_b = 0, valid_b = 0, last_b = 0;
    logic [31:0] data_b = '0;
    logic        ready_b, we_b, crst_b, done_b, err_b;
    logic [1:0]  addr_b;
    logic [31:0] wdata_b;
    logic [2:0]  wc_b;

    int n_cmp = 0;
    int n_err = 0;

    prog_boot_loader #(.ADDR_WIDTH(10), .RELEASE_DELAY(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .in_valid(valid_a),
        .in_ready(ready_a), .in_data(data_a), .in_last(last_a),
        .mem_we(we_a), .mem_addr(addr_a), .mem_wdata(wdata_a),
        .core_rst_n(crst_a), .done(done_a), .error(err_a), .word_count(wc_a)
    );

    prog_boot_loader #(.ADDR_WIDTH(2), .RELEASE_DELAY(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .in_valid(valid_b),
        .in_ready(ready_b), .in_data(data_b), .in_last(last_b),
        .mem_we(we_b), .mem_addr(addr_b), .mem_wdata(wdata_b),
        .core_rst_n(crst_b), .done(done_b), .error(err_b), .word_count(wc_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_crst", crst_a, 1'b0);
        chk("rst_ready", ready_a, 1'b0);
        chk("rst_we", we_a, 1'b0);
        chk("rst_addr", addr_a, 0);
        chk("rst_wdata", wdata_a, 0);
        chk("rst_done", done_a, 1'b0);
        chk("rst_err", err_a, 1'b0);
        chk("rst_wc", wc_a, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("idle_ready", ready_a, 1'b0);

        // Normal load
        start_a = 1; tick(); start_a = 0;
        chk("load_ready", ready_a, 1'b1);
        chk("load_crst", crst_a, 1'b0);
        valid_a = 1; data_a = 32'h0000_0013; tick();
        chk("n_we0", we_a, 1'b1); chk("n_addr0", addr_a, 0); chk("n_data0", wdata_a, 32'h0000_0013); chk("n_wc0", wc_a, 1);
        data_a = 32'h0010_0093; tick();
        chk("n_we1", we_a, 1'b1); chk("n_addr1", addr_a, 1); chk("n_data1", wdata_a, 32'h0010_0093); chk("n_wc1", wc_a, 2);
        data_a = 32'h0020_8133; last_a = 1; tick();
        chk("n_we2", we_a, 1'b1); chk("n_addr2", addr_a, 2); chk("n_data2", wdata_a, 32'h0020_8133); chk("n_wc2", wc_a, 3);
        chk("n_dly_ready", ready_a, 1'b0);
        chk("n_dly_crst", crst_a, 1'b0);
        valid_a = 0; last_a = 0;
        tick();
        chk("n_dly_we", we_a, 1'b0);
        chk("n_dly_crst1", crst_a, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("n_dly_crst_hold", crst_a, 1'b0);
        end
        tick();
        chk("n_run_crst", crst_a, 1'b1);
        chk("n_run_done", done_a, 1'b1);
        chk("n_run_wc", wc_a, 3);
        chk("n_run_we", we_a, 1'b0);
        // in_valid in RUN is ignored
        valid_a = 1; data_a = 32'hFFFF_FFFF; tick();
        chk("run_valid_we", we_a, 1'b0);
        chk("run_valid_wc", wc_a, 3);

        // Start with in_valid high: only the state change happens
        start_a = 1; tick(); start_a = 0;
        chk("rs_crst", crst_a, 1'b0);
        chk("rs_done", done_a, 1'b0);
        chk("rs_wc", wc_a, 0);
        chk("rs_we", we_a, 1'b0);
        chk("rs_ready", ready_a, 1'b1);

        // Gapped stream 1,0,1,0,1
        valid_a = 1; data_a = 32'hAAAA_0001; tick();
        chk("g_we0", we_a, 1'b1); chk("g_addr0", addr_a, 0); chk("g_wc0", wc_a, 1);
        valid_a = 0; data_a = 32'hDEAD_BEEF; tick();
        chk("g_gap0_we", we_a, 1'b0); chk("g_gap0_ready", ready_a, 1'b1); chk("g_gap0_wc", wc_a, 1);
        valid_a = 1; data_a = 32'hAAAA_0002; tick();
        chk("g_we1", we_a, 1'b1); chk("g_addr1", addr_a, 1); chk("g_data1", wdata_a, 32'hAAAA_0002);
        valid_a = 0; data_a = 32'hDEAD_BEEF; tick();
        chk("g_gap1_we", we_a, 1'b0); chk("g_gap1_ready", ready_a, 1'b1);
        valid_a = 1; data_a = 32'hAAAA_0003; last_a = 1; tick();
        chk("g_we2", we_a, 1'b1); chk("g_addr2", addr_a, 2); chk("g_data2", wdata_a, 32'hAAAA_0003); chk("g_wc2", wc_a, 3);
        valid_a = 0; last_a = 0;
        for (int i = 0; i < 5; i++) tick();
        chk("g_run_done", done_a, 1'b1);

        // Reload with 2 words
        start_a = 1; tick(); start_a = 0;
        chk("r_crst_drop", crst_a, 1'b0);
        valid_a = 1; data_a = 32'h0000_0011; tick();
        chk("r_addr0", addr_a, 0); chk("r_data0", wdata_a, 32'h0000_0011);
        data_a = 32'h0000_0022; last_a = 1; tick();
        chk("r_addr1", addr_a, 1); chk("r_data1", wdata_a, 32'h0000_0022); chk("r_wc", wc_a, 2);
        valid_a = 0; last_a = 0;
        for (int i = 0; i < 4; i++) tick();
        chk("r_crst_pre", crst_a, 1'b0);
        tick();
        chk("r_crst_rel", crst_a, 1'b1);
        chk("r_wc_hold", wc_a, 2);

        // Async reset mid-load
        start_a = 1; tick(); start_a = 0;
        valid_a = 1; data_a = 32'h0000_0101; tick();
        data_a = 32'h0000_0202; tick();
        chk("ar_we_pre", we_a, 1'b1);
        data_a = 32'h0000_0303;
        #2 rst_n = 1'b0;
        #1;
        chk("ar_we", we_a, 1'b0);
        chk("ar_crst", crst_a, 1'b0);
        chk("ar_ready", ready_a, 1'b0);
        chk("ar_wc", wc_a, 0);
        valid_a = 0;
        rst_n = 1'b1;
        tick();
        chk("ar_idle_ready", ready_a, 1'b0);
        chk("ar_idle_we", we_a, 1'b0);
        start_a = 1; tick(); start_a = 0;
        valid_a = 1; data_a = 32'h0000_0055; last_a = 1; tick();
        chk("ar_re_we", we_a, 1'b1); chk("ar_re_addr", addr_a, 0); chk("ar_re_data", wdata_a, 32'h0000_0055);
        valid_a = 0; last_a = 0;

        // Overflow on a 4-word memory
        start_b = 1; tick(); start_b = 0;
        valid_b = 1;
        for (int i = 0; i < 4; i++) begin
            data_b = 32'hB000_0000 + 32'(i);
            tick();
            chk("ov_we", we_b, 1'b1);
            chk("ov_addr", addr_b, 64'(i));
            chk("ov_data", wdata_b, 64'(32'hB000_0000 + 32'(i)));
        end
        chk("ov_err", err_b, 1'b1);
        chk("ov_crst", crst_b, 1'b0);
        chk("ov_ready", ready_b, 1'b0);
        chk("ov_wc", wc_b, 4);
        tick();
        chk("ov_err_we", we_b, 1'b0);
        chk("ov_err_hold", err_b, 1'b1);
        chk("ov_wc_hold", wc_b, 4);
        valid_b = 0;
        start_b = 1; tick(); start_b = 0;
        chk("ov_clr_err", err_b, 1'b0);
        chk("ov_clr_ready", ready_b, 1'b1);
        chk("ov_clr_wc", wc_b, 0);

        // RELEASE_DELAY=0: single word
        valid_b = 1; data_b = 32'h0000_0077; last_b = 1; tick();
        chk("d0_we", we_b, 1'b1); chk("d0_addr", addr_b, 0); chk("d0_data", wdata_b, 32'h0000_0077);
        chk("d0_crst_pre", crst_b, 1'b0); chk("d0_ready", ready_b, 1'b0);
        valid_b = 0; last_b = 0;
        tick();
        chk("d0_crst", crst_b, 1'b1); chk("d0_done", done_b, 1'b1); chk("d0_we_off", we_b, 1'b0);

        // in_last on the last address is a normal completion
        start_b = 1; tick(); start_b = 0;
        valid_b = 1;
        for (int i = 0; i < 4; i++) begin
            data_b = 32'hC000_0000 + 32'(i);
            last_b = (i == 3);
            tick();
        end
        chk("lt_addr", addr_b, 3);
        chk("lt_err", err_b, 1'b0);
        chk("lt_wc", wc_b, 4);
        valid_b = 0; last_b = 0;
        tick();
        chk("lt_crst", crst_b, 1'b1);
        chk("lt_err2", err_b, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
